// File: rtl/ir_pkg.sv
// Shared helpers for the instruction assembly register.
// Beat/lane mapping, beat-count derivation and parameter legality.
package ir_pkg;

    function automatic int beats_of(input int instr_w, input int bus_w);
        return instr_w / bus_w;
    endfunction

    // Lane filled by auto-sequenced beat number 'beat'.
    function automatic int lane_of(input int beat, input int beats,
                                   input int big_first);
        return (big_first != 0) ? beats - 1 - beat : beat;
    endfunction

    function automatic bit params_ok(input int bus_w, input int instr_w,
                                     input int depth);
        return bus_w > 0 && instr_w % bus_w == 0 &&
               instr_w / bus_w >= 2 && depth >= 1 &&
               (depth & (depth - 1)) == 0;
    endfunction

endpackage

// File: rtl/instr_assembly_reg_if.sv
// Bus bundle between memory/consumer and the instruction register.
// slave: seen from the register; master: seen from the driver side.
interface ir_if #(
    parameter int BUS_W   = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 2
);
    import ir_pkg::*;

    localparam int BEATS = beats_of(INSTR_W, BUS_W);
    localparam int LSW   = $clog2(BEATS);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [BUS_W-1:0]   InData;
    logic               InValid;
    logic               InReady;
    logic               LaneWrite;
    logic [LSW-1:0]     LaneSel;
    logic               Commit;
    logic               Flush;
    logic [INSTR_W-1:0] IROut;
    logic               IRValid;
    logic               IRReady;
    logic               Partial;
    logic [CW-1:0]      Count;

    modport master (
        output InData, InValid, LaneWrite, LaneSel, Commit, Flush,
        output IRReady,
        input  InReady, IROut, IRValid, Partial, Count
    );

    modport slave (
        input  InData, InValid, LaneWrite, LaneSel, Commit, Flush,
        input  IRReady,
        output InReady, IROut, IRValid, Partial, Count
    );

endinterface

// File: rtl/ir_queue.sv
// Synchronous FIFO of completed instructions with flush and count.
// Ports: Clock, Reset (async low), push/pop/flush, din, dout (head), count.
module ir_queue #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    // With one entry both pointers are pinned at 0.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (DEPTH == 1) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty && !flush;
        do_push = push && (!full || do_pop) && !flush;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= inc(wptr);
            if (do_pop)  rptr <= inc(rptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    // Storage needs no reset: stale entries are never visible past count.
    always_ff @(posedge Clock) begin
        if (do_push) mem[wptr] <= din;
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/instr_assembly_reg.sv
// Assembles INSTR_W instructions from BUS_W beats and queues them.
// Ports: Clock, Reset (async low), bus (ir_if.slave bundle).
module instr_assembly_reg
    import ir_pkg::*;
#(
    parameter int BUS_W     = 8,
    parameter int INSTR_W   = 16,
    parameter int DEPTH     = 2,
    parameter int BIG_FIRST = 1
) (
    input  logic Clock,
    input  logic Reset,
    ir_if.slave  bus
);
    localparam int BEATS = beats_of(INSTR_W, BUS_W);
    localparam int BW    = $clog2(BEATS);
    localparam int CW    = $clog2(DEPTH + 1);

    generate
        if (!params_ok(BUS_W, INSTR_W, DEPTH)) begin : g_bad_params
            $error("instr_assembly_reg: illegal BUS_W/INSTR_W/DEPTH");
        end
    endgenerate

    logic [BW-1:0]      beat;
    logic [BW-1:0]      beat_next;
    logic [INSTR_W-1:0] asm_q;
    logic [INSTR_W-1:0] asm_next;
    logic [INSTR_W-1:0] head;
    logic [CW-1:0]      count;
    logic               valid;
    logic               full;
    logic               pop;
    logic               last;
    logic               in_ready;
    logic               accept;
    logic               commit_ok;
    logic               push;
    int                 lane;

    always_comb begin
        valid     = (count != '0);
        full      = (count == CW'(DEPTH));
        pop       = valid && bus.IRReady;
        last      = (beat == BW'(BEATS - 1));
        // Only a word-completing action stalls on a full queue.
        in_ready  = !bus.Flush &&
                    !(full && !pop && (last || bus.Commit));
        accept    = bus.InValid && in_ready;
        commit_ok = bus.Commit && in_ready;
        lane      = bus.LaneWrite ? int'(bus.LaneSel)
                                  : lane_of(int'(beat), BEATS, BIG_FIRST);
        asm_next  = asm_q;
        beat_next = beat;
        push      = 1'b0;
        if (accept && lane < BEATS)
            asm_next[lane*BUS_W +: BUS_W] = bus.InData;
        if (accept && !bus.LaneWrite) begin
            if (last) begin
                push      = 1'b1;
                beat_next = '0;
            end else begin
                beat_next = beat + BW'(1);
            end
        end
        // The pushed word includes any lane written this cycle.
        if (commit_ok) begin
            push      = 1'b1;
            beat_next = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            beat  <= '0;
            asm_q <= '0;
        end else if (bus.Flush) begin
            beat  <= '0;
            asm_q <= '0;
        end else begin
            beat  <= beat_next;
            asm_q <= asm_next;
        end
    end

    ir_queue #(
        .W     (INSTR_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.Flush),
        .din   (asm_next),
        .dout  (head),
        .count (count)
    );

    assign bus.InReady = in_ready;
    assign bus.IRValid = valid;
    assign bus.IROut   = valid ? head : '0;
    assign bus.Partial = (beat != '0);
    assign bus.Count   = count;

endmodule
